tlb_op_ctrl: RTL and testbench

//  Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB).

---
 rtl/tlb_pkg.sv | 67 ++++++
 rtl/tlb_op_ctrl_if.sv | 47 ++++
 rtl/tlb_op_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB maintenance sequencer: op codes,
// entry image layout, CSR.TLBIDX packing and the response record.
package tlb_pkg;
    localparam int TLBNUM   = 16;
    localparam int IDXW     = $clog2(TLBNUM);
    localparam int ASID_W   = 10;
    localparam int VPPN_W   = 19;
    localparam int PS_W     = 6;
    localparam int ELO_W    = 27;
    localparam int INVOP_W  = 5;
    localparam int MASK_W   = 5;
    localparam int TLBIDX_W = IDXW + PS_W + 1;
    localparam int TLBW_W   = 1 + VPPN_W + PS_W + ASID_W + 1 + 2 * ELO_W;

    // ELO = {PPN[19:0], G, MAT[1:0], PLV[1:0], D, V}
    localparam int ELO_G = 6;

    // TLBIDX = {NE, PS[5:0], INDEX}
    localparam int IDX_PS_LSB = IDXW;
    localparam int IDX_NE     = IDXW + PS_W;

    // resp_we_mask = {ASID, TLBEHI, ELO0, ELO1, TLBIDX}
    localparam int MASK_TLBIDX = 0;

    localparam logic [INVOP_W-1:0] INV_MAX_OP = 5'd6;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } ctrl_state_e;

    // Field order matches tlb_w_bus / tlb_r_bus, MSB first.
    typedef struct packed {
        logic              e;
        logic [VPPN_W-1:0] vppn;
        logic [PS_W-1:0]   ps;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [ELO_W-1:0]  elo0;
        logic [ELO_W-1:0]  elo1;
    } tlb_entry_t;

    typedef struct packed {
        logic [MASK_W-1:0]   we_mask;
        logic [ASID_W-1:0]   asid;
        logic [VPPN_W-1:0]   tlbehi;
        logic [TLBIDX_W-1:0] tlbidx;
        logic [ELO_W-1:0]    elo0;
        logic [ELO_W-1:0]    elo1;
        logic                ine;
    } tlb_resp_t;

    function automatic logic [TLBIDX_W-1:0] pack_tlbidx(input logic ne,
                                                        input logic [PS_W-1:0] ps,
                                                        input logic [IDXW-1:0] idx);
        return {ne, ps, idx};
    endfunction
endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Request/response handshake between the WB-stage CSR file (master) and the
// TLB op sequencer (slave), including the CSR snapshot the op works on.
interface tlb_op_ctrl_if;
    import tlb_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [INVOP_W-1:0]    req_inv_op;
    logic [ASID_W-1:0]     req_inv_asid;
    logic [VPPN_W-1:0]     req_inv_vppn;

    logic [ASID_W-1:0]     csr_asid;
    logic [VPPN_W-1:0]     csr_tlbehi;
    logic [TLBIDX_W-1:0]   csr_tlbidx;
    logic [ELO_W-1:0]      csr_tlbelo0;
    logic [ELO_W-1:0]      csr_tlbelo1;
    logic                  csr_refill;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [MASK_W-1:0]     resp_we_mask;
    logic [ASID_W-1:0]     resp_asid;
    logic [VPPN_W-1:0]     resp_tlbehi;
    logic [TLBIDX_W-1:0]   resp_tlbidx;
    logic [ELO_W-1:0]      resp_elo0;
    logic [ELO_W-1:0]      resp_elo1;
    logic                  resp_ine;

    modport master (
        output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
        output csr_asid, csr_tlbehi, csr_tlbidx, csr_tlbelo0, csr_tlbelo1, csr_refill,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_we_mask, resp_asid, resp_tlbehi, resp_tlbidx,
        input  resp_elo0, resp_elo1, resp_ine
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
        input  csr_asid, csr_tlbehi, csr_tlbidx, csr_tlbelo0, csr_tlbelo1, csr_refill,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_we_mask, resp_asid, resp_tlbehi, resp_tlbidx,
        output resp_elo0, resp_elo1, resp_ine
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: one op at a time,
// IDLE -> EXEC (drives the TLB for one cycle) -> RESP (CSR update handshake).
module tlb_op_ctrl
    import tlb_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    tlb_op_ctrl_if.slave        ctl,
    output logic                tlb_s1_own,
    output logic [VPPN_W-1:0]   tlb_s1_vppn,
    output logic [ASID_W-1:0]   tlb_s1_asid,
    input  logic                tlb_s1_found,
    input  logic [IDXW-1:0]     tlb_s1_index,
    output logic                tlb_we,
    output logic [IDXW-1:0]     tlb_w_index,
    output logic [TLBW_W-1:0]   tlb_w_bus,
    output logic                tlb_invtlb_valid,
    output logic [INVOP_W-1:0]  tlb_invtlb_op,
    output logic [IDXW-1:0]     tlb_r_index,
    input  logic [TLBW_W-1:0]   tlb_r_bus
);
    ctrl_state_e         state_reg, state_next;
    tlb_op_e             op_reg;
    logic [INVOP_W-1:0]  inv_op_reg;
    logic [ASID_W-1:0]   inv_asid_reg;
    logic [VPPN_W-1:0]   inv_vppn_reg;
    logic [ASID_W-1:0]   asid_reg;
    logic [VPPN_W-1:0]   tlbehi_reg;
    logic [TLBIDX_W-1:0] tlbidx_reg;
    logic [ELO_W-1:0]    elo0_reg;
    logic [ELO_W-1:0]    elo1_reg;
    logic                refill_reg;
    logic [IDXW-1:0]     fill_cnt_reg;
    tlb_resp_t           resp_reg, resp_next;
    tlb_entry_t          w_entry, r_entry;
    logic [IDXW-1:0]     csr_index;
    logic [PS_W-1:0]     csr_ps;
    logic                inv_legal;

    assign r_entry   = tlb_entry_t'(tlb_r_bus);
    assign tlb_w_bus = w_entry;
    assign csr_index = tlbidx_reg[IDXW-1:0];
    assign csr_ps    = tlbidx_reg[IDX_NE-1:IDX_PS_LSB];
    assign inv_legal = (inv_op_reg <= INV_MAX_OP);

    assign ctl.req_ready    = (state_reg == ST_IDLE);
    assign ctl.resp_valid   = (state_reg == ST_RESP);
    assign ctl.resp_we_mask = resp_reg.we_mask;
    assign ctl.resp_asid    = resp_reg.asid;
    assign ctl.resp_tlbehi  = resp_reg.tlbehi;
    assign ctl.resp_tlbidx  = resp_reg.tlbidx;
    assign ctl.resp_elo0    = resp_reg.elo0;
    assign ctl.resp_elo1    = resp_reg.elo1;
    assign ctl.resp_ine     = resp_reg.ine;

    // Request and the CSR snapshot are latched together on acceptance so the
    // EXEC cycle works on a consistent view even if the CSR file moves on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_SRCH;
            inv_op_reg   <= '0;
            inv_asid_reg <= '0;
            inv_vppn_reg <= '0;
            asid_reg     <= '0;
            tlbehi_reg   <= '0;
            tlbidx_reg   <= '0;
            elo0_reg     <= '0;
            elo1_reg     <= '0;
            refill_reg   <= 1'b0;
            fill_cnt_reg <= '0;
            resp_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= (fill_cnt_reg == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt_reg + IDXW'(1);
            if (ctl.req_valid && ctl.req_ready) begin
                op_reg       <= tlb_op_e'(ctl.req_op);
                inv_op_reg   <= ctl.req_inv_op;
                inv_asid_reg <= ctl.req_inv_asid;
                inv_vppn_reg <= ctl.req_inv_vppn;
                asid_reg     <= ctl.csr_asid;
                tlbehi_reg   <= ctl.csr_tlbehi;
                tlbidx_reg   <= ctl.csr_tlbidx;
                elo0_reg     <= ctl.csr_tlbelo0;
                elo1_reg     <= ctl.csr_tlbelo1;
                refill_reg   <= ctl.csr_refill;
            end
            if (state_reg == ST_EXEC) begin
                resp_reg <= resp_next;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        tlb_s1_own       = 1'b0;
        tlb_s1_vppn      = '0;
        tlb_s1_asid      = '0;
        tlb_we           = 1'b0;
        tlb_w_index      = '0;
        w_entry          = '0;
        tlb_invtlb_valid = 1'b0;
        tlb_invtlb_op    = '0;
        tlb_r_index      = '0;
        resp_next        = '0;
        case (state_reg)
            ST_IDLE: begin
                if (ctl.req_valid) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_RESP;
                case (op_reg)
                    OP_SRCH: begin
                        tlb_s1_own  = 1'b1;
                        tlb_s1_vppn = tlbehi_reg;
                        tlb_s1_asid = asid_reg;
                        resp_next.we_mask[MASK_TLBIDX] = 1'b1;
                        resp_next.tlbidx = tlb_s1_found ? pack_tlbidx(1'b0, csr_ps, tlb_s1_index)
                                                        : pack_tlbidx(1'b1, csr_ps, csr_index);
                    end
                    OP_RD: begin
                        tlb_r_index       = csr_index;
                        resp_next.we_mask = '1;
                        // An invalid entry clears every read-back field except INDEX.
                        if (r_entry.e) begin
                            resp_next.asid   = r_entry.asid;
                            resp_next.tlbehi = r_entry.vppn;
                            resp_next.elo0   = r_entry.elo0;
                            resp_next.elo1   = r_entry.elo1;
                            resp_next.tlbidx = pack_tlbidx(1'b0, r_entry.ps, csr_index);
                        end else begin
                            resp_next.tlbidx = pack_tlbidx(1'b1, '0, csr_index);
                        end
                    end
                    OP_WR, OP_FILL: begin
                        tlb_we       = 1'b1;
                        tlb_w_index  = (op_reg == OP_FILL) ? fill_cnt_reg : csr_index;
                        w_entry.e    = refill_reg | ~tlbidx_reg[IDX_NE];
                        w_entry.vppn = tlbehi_reg;
                        w_entry.ps   = csr_ps;
                        w_entry.asid = asid_reg;
                        w_entry.g    = elo0_reg[ELO_G] & elo1_reg[ELO_G];
                        w_entry.elo0 = elo0_reg;
                        w_entry.elo1 = elo1_reg;
                    end
                    OP_INV: begin
                        tlb_s1_own       = 1'b1;
                        tlb_s1_vppn      = inv_vppn_reg;
                        tlb_s1_asid      = inv_asid_reg;
                        tlb_invtlb_valid = inv_legal;
                        tlb_invtlb_op    = inv_op_reg;
                        resp_next.ine    = ~inv_legal;
                    end
                    default: ;
                endcase
            end
            ST_RESP: begin
                if (ctl.resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl with a behavioural 16-entry TLB attached.
`timescale 1ns/1ps
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tlb_op_ctrl_if ctl();

    logic               tlb_s1_own, tlb_s1_found, tlb_we, tlb_invtlb_valid;
    logic [VPPN_W-1:0]  tlb_s1_vppn;
    logic [ASID_W-1:0]  tlb_s1_asid;
    logic [IDXW-1:0]    tlb_s1_index, tlb_w_index, tlb_r_index;
    logic [TLBW_W-1:0]  tlb_w_bus, tlb_r_bus;
    logic [INVOP_W-1:0] tlb_invtlb_op;

    tlb_op_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .ctl              (ctl),
        .tlb_s1_own       (tlb_s1_own),
        .tlb_s1_vppn      (tlb_s1_vppn),
        .tlb_s1_asid      (tlb_s1_asid),
        .tlb_s1_found     (tlb_s1_found),
        .tlb_s1_index     (tlb_s1_index),
        .tlb_we           (tlb_we),
        .tlb_w_index      (tlb_w_index),
        .tlb_w_bus        (tlb_w_bus),
        .tlb_invtlb_valid (tlb_invtlb_valid),
        .tlb_invtlb_op    (tlb_invtlb_op),
        .tlb_r_index      (tlb_r_index),
        .tlb_r_bus        (tlb_r_bus)
    );

    // ---------------- behavioural TLB ----------------
    tlb_entry_t        tlb_mem [TLBNUM];
    logic              load_en = 1'b0;
    logic [IDXW-1:0]   load_idx = '0;
    tlb_entry_t        load_val = '0;

    function automatic logic [IDXW:0] tb_search(input logic [VPPN_W-1:0] v, input logic [ASID_W-1:0] a);
        for (int i = 0; i < TLBNUM; i++)
            if (tlb_mem[i].e && tlb_mem[i].vppn == v && (tlb_mem[i].g || tlb_mem[i].asid == a))
                return {1'b1, IDXW'(i)};
        return '0;
    endfunction

    function automatic logic inv_hit(input tlb_entry_t t, input logic [INVOP_W-1:0] op,
                                     input logic [ASID_W-1:0] a, input logic [VPPN_W-1:0] v);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return t.g;
            5'd3:       return !t.g;
            5'd4:       return !t.g && t.asid == a;
            5'd5:       return !t.g && t.asid == a && t.vppn == v;
            5'd6:       return (t.g || t.asid == a) && t.vppn == v;
            default:    return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_en) tlb_mem[load_idx] <= load_val;
        if (tlb_we) tlb_mem[tlb_w_index] <= tlb_entry_t'(tlb_w_bus);
        if (tlb_invtlb_valid)
            for (int i = 0; i < TLBNUM; i++)
                if (inv_hit(tlb_mem[i], tlb_invtlb_op, tlb_s1_asid, tlb_s1_vppn)) tlb_mem[i].e <= 1'b0;
    end

    always_comb {tlb_s1_found, tlb_s1_index} = tb_search(tlb_s1_vppn, tlb_s1_asid);
    assign tlb_r_bus = tlb_mem[tlb_r_index];

    // Cycles since reset release; equals the expected fill counter value.
    int unsigned cyc;
    always @(posedge clk or negedge resetn)
        if (!resetn) cyc <= 0; else cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic            use_fill;
        logic [IDXW-1:0] idx;
        tlb_entry_t      ent;
    } wr_exp_t;

    typedef struct packed {
        logic [INVOP_W-1:0] op;
        logic [ASID_W-1:0]  asid;
        logic [VPPN_W-1:0]  vppn;
    } inv_exp_t;

    tlb_resp_t   resp_q[$];
    string       tag_q[$];
    wr_exp_t     wr_q[$];
    inv_exp_t    inv_q[$];
    int unsigned fill_cyc[$];
    logic [IDXW-1:0] fill_idx[$];
    int          resp_cnt = 0;

    tlb_resp_t mon_cur, mon_held, mon_exp;
    bit        mon_hold = 1'b0;
    wr_exp_t   mon_w;
    inv_exp_t  mon_i;
    string     mon_tag;

    always begin
        @(negedge clk);
        #1;
        if (!resetn) begin
            mon_hold = 1'b0;
        end else begin
            if (tlb_we) begin
                if (wr_q.size() == 0) check("we_unexpected", 1, 0);
                else begin
                    mon_w = wr_q.pop_front();
                    check("w_index", tlb_w_index, mon_w.use_fill ? IDXW'(cyc % TLBNUM) : mon_w.idx);
                    check("w_bus", tlb_w_bus, mon_w.ent);
                    $display("  tlb write idx=%0d bus=0x%0h", tlb_w_index, tlb_w_bus);
                    if (mon_w.use_fill) begin
                        fill_cyc.push_back(cyc);
                        fill_idx.push_back(tlb_w_index);
                    end
                end
            end
            if (tlb_invtlb_valid) begin
                if (inv_q.size() == 0) check("invtlb_unexpected", 1, 0);
                else begin
                    mon_i = inv_q.pop_front();
                    check("invtlb_key", {tlb_invtlb_op, tlb_s1_asid, tlb_s1_vppn}, mon_i);
                end
            end
            if (ctl.resp_valid) begin
                mon_cur.we_mask = ctl.resp_we_mask;
                mon_cur.asid    = ctl.resp_asid;
                mon_cur.tlbehi  = ctl.resp_tlbehi;
                mon_cur.tlbidx  = ctl.resp_tlbidx;
                mon_cur.elo0    = ctl.resp_elo0;
                mon_cur.elo1    = ctl.resp_elo1;
                mon_cur.ine     = ctl.resp_ine;
                if (mon_hold) check("resp_stable", mon_cur, mon_held);
                if (ctl.resp_ready) begin
                    if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
                    else begin
                        mon_exp = resp_q.pop_front();
                        mon_tag = tag_q.pop_front();
                        check(mon_tag, mon_cur, mon_exp);
                        $display("  resp %s mask=%b tlbidx=0x%0h ine=%b", mon_tag,
                                 mon_cur.we_mask, mon_cur.tlbidx, mon_cur.ine);
                    end
                    resp_cnt++;
                    mon_hold = 1'b0;
                end else begin
                    mon_hold = 1'b1;
                    mon_held = mon_cur;
                end
            end else begin
                mon_hold = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [ELO_W-1:0] mk_elo(input logic [19:0] ppn, input logic g);
        return {ppn, g, 2'b01, 2'b00, 1'b1, 1'b1};
    endfunction

    task automatic set_csr(input logic [ASID_W-1:0] asid, input logic [VPPN_W-1:0] ehi,
                           input logic ne, input logic [PS_W-1:0] ps, input logic [IDXW-1:0] idx,
                           input logic [ELO_W-1:0] e0, input logic [ELO_W-1:0] e1, input logic refill);
        ctl.csr_asid    = asid;
        ctl.csr_tlbehi  = ehi;
        ctl.csr_tlbidx  = {ne, ps, idx};
        ctl.csr_tlbelo0 = e0;
        ctl.csr_tlbelo1 = e1;
        ctl.csr_refill  = refill;
    endtask

    task automatic load_entry(input int idx, input tlb_entry_t v);
        @(negedge clk);
        load_en  = 1'b1;
        load_idx = IDXW'(idx);
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic do_op(input string tag, input tlb_op_e op, input logic [INVOP_W-1:0] iop,
                         input logic [ASID_W-1:0] ia, input logic [VPPN_W-1:0] iv, input int ready_delay);
        tlb_resp_t       r;
        wr_exp_t         w;
        tlb_entry_t      ent;
        logic [IDXW:0]   s;
        logic [IDXW-1:0] idx;
        logic [PS_W-1:0] ps;
        bit              ok;
        int              start;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ctl.req_ready) ok = 1'b1;
        end
        check({tag, "_req_ready"}, ok, 1);
        idx = ctl.csr_tlbidx[IDXW-1:0];
        ps  = ctl.csr_tlbidx[IDX_NE-1:IDX_PS_LSB];
        r   = '0;
        case (op)
            OP_SRCH: begin
                s = tb_search(ctl.csr_tlbehi, ctl.csr_asid);
                r.we_mask = 5'b00001;
                r.tlbidx  = s[IDXW] ? {1'b0, ps, s[IDXW-1:0]} : {1'b1, ps, idx};
            end
            OP_RD: begin
                ent = tlb_mem[idx];
                r.we_mask = 5'b11111;
                if (ent.e) begin
                    r.asid = ent.asid; r.tlbehi = ent.vppn;
                    r.elo0 = ent.elo0; r.elo1 = ent.elo1;
                    r.tlbidx = {1'b0, ent.ps, idx};
                end else begin
                    r.tlbidx = {1'b1, 6'd0, idx};
                end
            end
            OP_WR, OP_FILL: begin
                w.use_fill = (op == OP_FILL);
                w.idx      = idx;
                w.ent.e    = ctl.csr_refill | ~ctl.csr_tlbidx[IDX_NE];
                w.ent.vppn = ctl.csr_tlbehi;
                w.ent.ps   = ps;
                w.ent.asid = ctl.csr_asid;
                w.ent.g    = ctl.csr_tlbelo0[ELO_G] & ctl.csr_tlbelo1[ELO_G];
                w.ent.elo0 = ctl.csr_tlbelo0;
                w.ent.elo1 = ctl.csr_tlbelo1;
                wr_q.push_back(w);
            end
            OP_INV: begin
                if (iop <= 5'd6) inv_q.push_back({iop, ia, iv});
                else r.ine = 1'b1;
            end
            default: ;
        endcase
        resp_q.push_back(r);
        tag_q.push_back(tag);
        ctl.resp_ready   = (ready_delay == 0);
        ctl.req_valid    = 1'b1;
        ctl.req_op       = op;
        ctl.req_inv_op   = iop;
        ctl.req_inv_asid = ia;
        ctl.req_inv_vppn = iv;
        start = resp_cnt;
        @(negedge clk);
        ctl.req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (i + 1 >= ready_delay) ctl.resp_ready = 1'b1;
            #2;
            if (resp_cnt != start) ok = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_resp_done"}, ok, 1);
    endtask

    tlb_entry_t ent;
    bit         seen;

    initial begin
        ctl.req_valid = 1'b0; ctl.req_op = '0; ctl.req_inv_op = '0;
        ctl.req_inv_asid = '0; ctl.req_inv_vppn = '0; ctl.resp_ready = 1'b1;
        set_csr('0, '0, 1'b0, '0, '0, '0, '0, 1'b0);

        for (int i = 0; i < TLBNUM; i++) load_entry(i, '0);
        ent = '0; ent.e = 1'b1; ent.vppn = 19'h01234; ent.asid = 10'd3; ent.ps = 6'd12;
        ent.elo0 = mk_elo(20'h00aaa, 1'b0); ent.elo1 = mk_elo(20'h00aab, 1'b0);
        load_entry(5, ent);
        ent = '0; ent.e = 1'b0; ent.vppn = 19'h07777; ent.asid = 10'h155; ent.g = 1'b1; ent.ps = 6'd13;
        ent.elo0 = mk_elo(20'hfffff, 1'b1); ent.elo1 = mk_elo(20'h12345, 1'b1);
        load_entry(7, ent);
        ent = '0; ent.e = 1'b1; ent.vppn = 19'h01234; ent.asid = 10'd7; ent.ps = 6'd12;
        load_entry(8, ent);

        // Reset state
        check("rst_req_ready", ctl.req_ready, 1);
        check("rst_resp_valid", ctl.resp_valid, 0);
        check("rst_resp_data", {ctl.resp_we_mask, ctl.resp_tlbidx, ctl.resp_asid, ctl.resp_ine}, 0);
        check("rst_tlb_strobes", {tlb_we, tlb_invtlb_valid, tlb_s1_own}, 0);
        @(negedge clk);
        resetn = 1'b1;

        set_csr(10'd3, 19'h01234, 1'b1, 6'd12, 4'd2, '0, '0, 1'b0);
        do_op("srch_hit", OP_SRCH, '0, '0, '0, 0);
        set_csr(10'd4, 19'h01234, 1'b1, 6'd12, 4'd2, '0, '0, 1'b0);
        do_op("srch_miss", OP_SRCH, '0, '0, '0, 0);

        set_csr(10'd1, 19'h00001, 1'b0, 6'd9, 4'd7, '0, '0, 1'b0);
        do_op("rd_invalid", OP_RD, '0, '0, '0, 0);

        set_csr(10'h012, 19'h0abcd, 1'b0, 6'd21, 4'd7, mk_elo(20'h11111, 1'b1), mk_elo(20'h22222, 1'b1), 1'b0);
        do_op("wr_idx7_held", OP_WR, '0, '0, '0, 3);
        do_op("rd_valid", OP_RD, '0, '0, '0, 0);

        set_csr(10'd2, 19'h04444, 1'b1, 6'd12, 4'd9, mk_elo(20'h1, 1'b1), mk_elo(20'h2, 1'b0), 1'b0);
        do_op("wr_ne_norefill", OP_WR, '0, '0, '0, 0);
        check("wr9_e", tlb_mem[9].e, 0);
        set_csr(10'd2, 19'h04444, 1'b1, 6'd12, 4'd10, mk_elo(20'h1, 1'b1), mk_elo(20'h2, 1'b0), 1'b1);
        do_op("wr_ne_refill", OP_WR, '0, '0, '0, 0);
        check("wr10_e", tlb_mem[10].e, 1);

        set_csr(10'd3, 19'h01234, 1'b0, 6'd12, 4'd6, mk_elo(20'h3, 1'b1), mk_elo(20'h4, 1'b1), 1'b0);
        do_op("wr_global6", OP_WR, '0, '0, '0, 0);
        do_op("inv5", OP_INV, 5'd5, 10'd3, 19'h01234, 0);
        @(negedge clk);
        check("inv5_entry5_cleared", tlb_mem[5].e, 0);
        check("inv5_global_kept", tlb_mem[6].e, 1);
        check("inv5_other_asid_kept", tlb_mem[8].e, 1);
        do_op("inv9_ine", OP_INV, 5'd9, 10'd3, 19'h01234, 0);
        check("inv9_entries_kept", {tlb_mem[6].e, tlb_mem[8].e}, 2'b11);

        set_csr(10'd5, 19'h05555, 1'b0, 6'd12, 4'd0, mk_elo(20'h5, 1'b0), mk_elo(20'h6, 1'b0), 1'b0);
        do_op("fill_a", OP_FILL, '0, '0, '0, 0);
        repeat (3) @(negedge clk);
        do_op("fill_b", OP_FILL, '0, '0, '0, 0);
        check("fill_pulses", fill_idx.size(), 2);
        if (fill_idx.size() == 2)
            check("fill_delta", IDXW'(fill_idx[1] - fill_idx[0]), IDXW'(fill_cyc[1] - fill_cyc[0]));

        // Reset while a response is pending and unaccepted
        ctl.resp_ready = 1'b0;
        @(negedge clk);
        ctl.req_valid = 1'b1;
        ctl.req_op    = OP_SRCH;
        @(negedge clk);
        ctl.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ctl.resp_valid) seen = 1'b1;
        end
        check("abort_resp_seen", seen, 1);
        resetn = 1'b0;
        #1;
        check("abort_resp_valid", ctl.resp_valid, 0);
        check("abort_req_ready", ctl.req_ready, 1);
        check("abort_strobes", {tlb_we, tlb_invtlb_valid}, 0);
        @(negedge clk);
        resetn = 1'b1;
        set_csr(10'd7, 19'h01234, 1'b1, 6'd12, 4'd3, '0, '0, 1'b0);
        do_op("post_reset_srch", OP_SRCH, '0, '0, '0, 0);

        repeat (3) @(negedge clk);
        check("resp_q_drained", resp_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        check("inv_q_drained", inv_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
